// File: rtl/acc_drain.sv
// acc_drain: walks a window of accumulator rows, requantizes each 16x20b row
// to 16x8b (rounding arithmetic shift + saturation) and streams the rows out
// through a 2-entry valid/ready FIFO that absorbs any amount of backpressure.
// Optional build macro: RELU_EN (negative lanes are forced to zero before
// the shift).

// Per-lane requantizer: round-half-up arithmetic shift, then saturate.
module acc_drain_lane #(
  parameter int DATA_SIZE = 20,
  parameter int OUT_SIZE  = 8
) (
  input  logic [DATA_SIZE-1:0] x,
  input  logic [4:0]           sh,
  output logic [OUT_SIZE-1:0]  y
);
  localparam int QMAXI = 2**(OUT_SIZE-1) - 1;
  localparam int QMINI = -(2**(OUT_SIZE-1));
  localparam logic signed [DATA_SIZE:0] QMAX = QMAXI[DATA_SIZE:0];
  localparam logic signed [DATA_SIZE:0] QMIN = QMINI[DATA_SIZE:0];

  logic signed [DATA_SIZE:0] xe, rnd, t;

  // One extra bit of headroom so the rounding add cannot overflow.
  always_comb begin
    xe = $signed({x[DATA_SIZE-1], x});
`ifdef RELU_EN
    if (xe < 0) xe = '0;
`endif
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    t = (xe + rnd) >>> sh;
    if (t > QMAX)      y = QMAX[OUT_SIZE-1:0];
    else if (t < QMIN) y = QMIN[OUT_SIZE-1:0];
    else               y = t[OUT_SIZE-1:0];
  end
endmodule

module acc_drain #(
  parameter int DATA_SIZE = 20,
  parameter int DATA_NUM  = 16,
  parameter int OUT_SIZE  = 8,
  parameter int ADDR_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W:0]               row_cnt,
  input  logic [4:0]                    shift,
  output logic                          busy,
  output logic                          done,
  output logic                          acc_enb,
  output logic [ADDR_W-1:0]             acc_addrb,
  input  logic [DATA_NUM*DATA_SIZE-1:0] acc_doutb,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_NUM*OUT_SIZE-1:0]  m_data,
  output logic                          m_last
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  typedef struct packed {
    logic                               last;
    logic [DATA_NUM-1:0][OUT_SIZE-1:0]  data;
  } beat_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [4:0]        sh_q;

  beat_t             fifo_q [2];
  logic [1:0]        occ;
  logic              wr_ptr, rd_ptr;

  logic [DATA_NUM-1:0][OUT_SIZE-1:0] q_row;
  logic issue, last_issue, pop, flush_ok;

  // Reads issue only while the registered occupancy leaves room, so a row
  // read this cycle always has a slot at the edge that captures it.
  assign issue      = (state == READ) && (occ != 2'd2);
  assign last_issue = issue && (rem_q == (ADDR_W+1)'(1));
  assign pop        = m_valid && m_ready;
  assign flush_ok   = (occ == 2'd0) || ((occ == 2'd1) && pop);

  // Lane array: requantize the row arriving from the accumulator.
  for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
    acc_drain_lane #(.DATA_SIZE(DATA_SIZE), .OUT_SIZE(OUT_SIZE)) u_lane (
      .x  (acc_doutb[i*DATA_SIZE +: DATA_SIZE]),
      .sh (sh_q),
      .y  (q_row[i])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (row_cnt == '0) ? DONE : READ;
      READ:  if (last_issue) state_nx = FLUSH;
      FLUSH: if (flush_ok) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy    = (state == READ) || (state == FLUSH);
    done    = (state == DONE);
    acc_enb = issue;
  end

  // Command latch and read walker; the address wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      sh_q   <= '0;
    end else if ((state == IDLE) && start) begin
      addr_q <= base_addr;
      rem_q  <= row_cnt;
      sh_q   <= (shift > 5'd19) ? 5'd19 : shift;
    end else if (issue) begin
      addr_q <= addr_q + ADDR_W'(1);
      rem_q  <= rem_q - (ADDR_W+1)'(1);
    end
  end

  assign acc_addrb = addr_q;

  // Output FIFO: push at the edge that ends a read cycle, pop on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      if (issue) begin
        fifo_q[wr_ptr] <= '{last: last_issue, data: q_row};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({issue, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = fifo_q[rd_ptr].data;
  assign m_last  = m_valid && fifo_q[rd_ptr].last;
endmodule
